// File: rtl/gate_controller_if.sv
// Gate controller bus: the sensor/ticket inputs, the parking-FSM handshake and
// the barrier motor/status outputs. Clock and reset stay outside as plain ports.
//   master : the gate_controller side (drives requests, motor and status)
//   slave  : the environment side (drives sensors, ticket slot and FSM response)
// Signals:
//   car_at_entry, car_at_exit : raw lane presence sensors
//   exit_slot_sel[1:0]        : ticket slot of the exiting car
//   is_open, is_full          : registered FSM response, valid one cycle after a request
//   entry_signal, exit_signal : one-cycle requests to the parking FSM
//   exit_slot[1:0]            : slot number accompanying an exit request
//   gate_up, gate_down        : barrier motor drive (mutually exclusive)
//   gate_is_up                : barrier fully raised
//   reject_full, reject_invalid : request refused flags
//   busy                      : controller is not idle
interface gate_controller_if;
  logic       car_at_entry;
  logic       car_at_exit;
  logic [1:0] exit_slot_sel;
  logic       is_open;
  logic       is_full;
  logic       entry_signal;
  logic       exit_signal;
  logic [1:0] exit_slot;
  logic       gate_up;
  logic       gate_down;
  logic       gate_is_up;
  logic       reject_full;
  logic       reject_invalid;
  logic       busy;

  modport master (
    input  car_at_entry, car_at_exit, exit_slot_sel, is_open, is_full,
    output entry_signal, exit_signal, exit_slot, gate_up, gate_down,
           gate_is_up, reject_full, reject_invalid, busy
  );

  modport slave (
    output car_at_entry, car_at_exit, exit_slot_sel, is_open, is_full,
    input  entry_signal, exit_signal, exit_slot, gate_up, gate_down,
           gate_is_up, reject_full, reject_invalid, busy
  );
endinterface

// File: rtl/gate_controller.sv
// Parking gate front end: debounces the entry and exit car sensors, arbitrates
// between the lanes (exit first), issues one request per car to the parking
// FSM, samples its grant one cycle later and sequences the barrier motor
// through raise, pass (with timeout) and lower, or holds a reject flag.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   gc    : gate_controller_if.master (sensors, FSM handshake, motor, status)
module gate_controller #(
  parameter int unsigned DEBOUNCE_CYCLES  = 4,
  parameter int unsigned GATE_MOVE_CYCLES = 8,
  parameter int unsigned PASS_TIMEOUT     = 64,
  parameter int unsigned REJECT_CYCLES    = 4
) (
  input  logic              clk,
  input  logic              reset,
  gate_controller_if.master gc
);

  localparam int unsigned MAX_A   = (DEBOUNCE_CYCLES > GATE_MOVE_CYCLES) ? DEBOUNCE_CYCLES : GATE_MOVE_CYCLES;
  localparam int unsigned MAX_B   = (PASS_TIMEOUT > REJECT_CYCLES) ? PASS_TIMEOUT : REJECT_CYCLES;
  localparam int unsigned MAX_P   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_P) + 1;
  localparam int unsigned N_LANES = 2;
  localparam int unsigned SLOT_W  = 2;

  // Terminal counter values: a phase ends on the edge where its counter holds LAST.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(GATE_MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PASS_LAST = CNT_W'(PASS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REJ_LAST  = CNT_W'(REJECT_CYCLES - 1);

  // Lane index into the per-lane vectors: bit 0 entry, bit 1 exit.
  localparam int unsigned IDX_ENTRY = 0;
  localparam int unsigned IDX_EXIT  = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_RESP   = 3'd2,
    ST_RAISE  = 3'd3,
    ST_PASS   = 3'd4,
    ST_LOWER  = 3'd5,
    ST_REJECT = 3'd6
  } state_e;

  typedef enum logic {
    LANE_ENTRY = 1'b0,
    LANE_EXIT  = 1'b1
  } lane_e;

  state_e                          state_q, state_d;
  lane_e                           lane_q, lane_d;
  logic [SLOT_W-1:0]               slot_q, slot_d;
  logic [CNT_W-1:0]                tmr_q, tmr_d;

  logic [N_LANES-1:0]              raw_c;
  logic [N_LANES-1:0]              lvl_q, lvl_d;
  logic [N_LANES-1:0]              prev_q;
  logic [N_LANES-1:0]              rise_c;
  logic [N_LANES-1:0]              req_c;
  logic [N_LANES-1:0]              pend_q, pend_d;
  logic [N_LANES-1:0][CNT_W-1:0]   db_cnt_q, db_cnt_d;
  logic                            served_lvl_c;

  logic entry_signal_q, entry_signal_d;
  logic exit_signal_q, exit_signal_d;
  logic gate_up_q, gate_up_d;
  logic gate_down_q, gate_down_d;
  logic gate_is_up_q, gate_is_up_d;
  logic reject_full_q, reject_full_d;
  logic reject_invalid_q, reject_invalid_d;
  logic busy_q, busy_d;

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    raw_c    = {gc.car_at_exit, gc.car_at_entry};
    lvl_d    = lvl_q;
    db_cnt_d = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (raw_c[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Events come from debounced rising edges; pending ones die if the car leaves first.
  assign rise_c       = lvl_q & ~prev_q;
  assign req_c        = (pend_q | rise_c) & lvl_q;
  assign served_lvl_c = (lane_q == LANE_EXIT) ? lvl_q[IDX_EXIT] : lvl_q[IDX_ENTRY];

  // Next state, lane/slot latch, phase timer and next registered outputs.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    slot_d  = slot_q;
    tmr_d   = '0;
    pend_d  = req_c;

    unique case (state_q)
      ST_IDLE: begin
        // Exit wins: a departure frees capacity for the waiting entry.
        if (req_c[IDX_EXIT]) begin
          state_d          = ST_REQ;
          lane_d           = LANE_EXIT;
          slot_d           = gc.exit_slot_sel;
          pend_d[IDX_EXIT] = 1'b0;
        end else if (req_c[IDX_ENTRY]) begin
          state_d           = ST_REQ;
          lane_d            = LANE_ENTRY;
          pend_d[IDX_ENTRY] = 1'b0;
        end
      end
      ST_REQ: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // The lane alone selects which reject flag is raised; a full lot only refuses entries.
        if (gc.is_open) begin
          state_d = ST_RAISE;
        end else if (lane_q == LANE_ENTRY && gc.is_full) begin
          state_d = ST_REJECT;
        end else begin
          state_d = ST_REJECT;
        end
      end
      ST_RAISE: begin
        if (tmr_q == MOVE_LAST) begin
          state_d = ST_PASS;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      ST_PASS: begin
        if (!served_lvl_c || tmr_q == PASS_LAST) begin
          state_d = ST_LOWER;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      ST_LOWER: begin
        if (tmr_q == MOVE_LAST) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      ST_REJECT: begin
        if (tmr_q == REJ_LAST) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    entry_signal_d   = (state_d == ST_REQ) && (lane_d == LANE_ENTRY);
    exit_signal_d    = (state_d == ST_REQ) && (lane_d == LANE_EXIT);
    gate_up_d        = (state_d == ST_RAISE);
    gate_down_d      = (state_d == ST_LOWER);
    gate_is_up_d     = (state_d == ST_PASS);
    reject_full_d    = (state_d == ST_REJECT) && (lane_d == LANE_ENTRY);
    reject_invalid_d = (state_d == ST_REJECT) && (lane_d == LANE_EXIT);
    busy_d           = (state_d != ST_IDLE);
  end

  // All state; reset clears motor drive immediately, independent of the clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      lane_q           <= LANE_ENTRY;
      slot_q           <= '0;
      tmr_q            <= '0;
      lvl_q            <= '0;
      prev_q           <= '0;
      pend_q           <= '0;
      db_cnt_q         <= '0;
      entry_signal_q   <= 1'b0;
      exit_signal_q    <= 1'b0;
      gate_up_q        <= 1'b0;
      gate_down_q      <= 1'b0;
      gate_is_up_q     <= 1'b0;
      reject_full_q    <= 1'b0;
      reject_invalid_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      lane_q           <= lane_d;
      slot_q           <= slot_d;
      tmr_q            <= tmr_d;
      lvl_q            <= lvl_d;
      prev_q           <= lvl_q;
      pend_q           <= pend_d;
      db_cnt_q         <= db_cnt_d;
      entry_signal_q   <= entry_signal_d;
      exit_signal_q    <= exit_signal_d;
      gate_up_q        <= gate_up_d;
      gate_down_q      <= gate_down_d;
      gate_is_up_q     <= gate_is_up_d;
      reject_full_q    <= reject_full_d;
      reject_invalid_q <= reject_invalid_d;
      busy_q           <= busy_d;
    end
  end

  assign gc.entry_signal   = entry_signal_q;
  assign gc.exit_signal    = exit_signal_q;
  assign gc.exit_slot      = slot_q;
  assign gc.gate_up        = gate_up_q;
  assign gc.gate_down      = gate_down_q;
  assign gc.gate_is_up     = gate_is_up_q;
  assign gc.reject_full    = reject_full_q;
  assign gc.reject_invalid = reject_invalid_q;
  assign gc.busy           = busy_q;

endmodule

// File: tb/tb_gate_controller.sv
// Scoreboard bench for gate_controller: stimulus plans each car's passage and
// pushes the expected output pulses (signal, start cycle, length, slot); a
// monitor measures every output pulse and pops/compares; a responder plays
// the parking FSM with garbage on is_open/is_full outside the response cycle.
module tb_gate_controller;

  localparam int DB = 4;
  localparam int MV = 8;
  localparam int PT = 64;
  localparam int RJ = 4;

  localparam int K_ENTRY = 0;
  localparam int K_EXIT  = 1;
  localparam int K_UP    = 2;
  localparam int K_ISUP  = 3;
  localparam int K_DOWN  = 4;
  localparam int K_RFULL = 5;
  localparam int K_RINV  = 6;
  localparam int K_BUSY  = 7;

  localparam int RS_GRANT = 0;
  localparam int RS_FULL  = 1;
  localparam int RS_DENY  = 2;

  typedef struct {
    int kind;
    int start;
    int len;
    int slot;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   compared = 0;
  int   mism = 0;
  bit   mon_en = 1'b0;
  bit   req_seen = 1'b0;
  exp_t exp_q[$];
  int   resp_q[$];
  string sig_name[8] = '{"entry_signal", "exit_signal", "gate_up", "gate_is_up",
                         "gate_down", "reject_full", "reject_invalid", "busy"};

  gate_controller_if gc();

  gate_controller #(
    .DEBOUNCE_CYCLES (DB),
    .GATE_MOVE_CYCLES(MV),
    .PASS_TIMEOUT    (PT),
    .REJECT_CYCLES   (RJ)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .gc   (gc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] outs_c();
    return {gc.busy, gc.reject_invalid, gc.reject_full, gc.gate_down, gc.gate_is_up,
            gc.gate_up, gc.exit_signal, gc.entry_signal, gc.exit_slot};
  endfunction

  task automatic push(input int kind, input int start, input int len, input int slot);
    exp_t e;
    e.kind = kind; e.start = start; e.len = len; e.slot = slot;
    exp_q.push_back(e);
  endtask

  // Expected pulses for one served request starting at cycle r; returns the cycle busy drops.
  task automatic plan(input bit is_exit, input int slot, input int r, input int resp,
                      input int k, output int idle);
    int l;
    push(is_exit ? K_EXIT : K_ENTRY, r, 1, slot);
    resp_q.push_back(resp);
    if (resp == RS_GRANT) begin
      // car leaves k cycles into PASS; the debounced level falls DB samples later
      l = (k + DB + 1 < PT) ? k + DB + 1 : PT;
      push(K_UP, r + 2, MV, 0);
      push(K_ISUP, r + 2 + MV, l, 0);
      push(K_DOWN, r + 2 + MV + l, MV, 0);
      push(K_BUSY, r, 2 + 2 * MV + l, 0);
      idle = r + 2 + 2 * MV + l;
    end else begin
      push(is_exit ? K_RINV : K_RFULL, r + 2, RJ, 0);
      push(K_BUSY, r, 2 + RJ, 0);
      idle = r + 2 + RJ;
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_raw(input bit is_exit, input bit v);
    if (is_exit) gc.car_at_exit = v;
    else         gc.car_at_entry = v;
  endtask

  task automatic check_pulse(input int kind, input int s, input int len, input int slot);
    exp_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mism++;
      $display("FAIL unexpected_pulse %s got start=%0d len=%0d slot=%0d, required none",
               sig_name[kind], s, len, slot);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.start != s || e.len != len || (kind == K_EXIT && e.slot != slot)) begin
        mism++;
        $display("FAIL pulse_%s got %s start=%0d len=%0d slot=%0d, required %s start=%0d len=%0d slot=%0d",
                 sig_name[e.kind], sig_name[kind], s, len, slot,
                 sig_name[e.kind], e.start, e.len, e.slot);
      end
    end
  endtask

  // Parking FSM stand-in: answers in the cycle after a request, noise otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (gc.entry_signal || gc.exit_signal) req_seen = 1'b1;
    end
  end

  initial begin
    int r;
    gc.is_open = 1'b0;
    gc.is_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (req_seen) begin
        req_seen = 1'b0;
        r = (resp_q.size() > 0) ? resp_q.pop_front() : RS_DENY;
        gc.is_open = (r == RS_GRANT);
        gc.is_full = (r == RS_FULL);
      end else begin
        gc.is_open = 1'($urandom);
        gc.is_full = 1'($urandom);
      end
    end
  end

  // Pulse monitor: measures each output pulse and checks it against the scoreboard.
  initial begin
    logic [7:0] cur;
    logic [7:0] prv;
    int st[8];
    int slot_seen;
    prv = '0;
    slot_seen = 0;
    for (int i = 0; i < 8; i++) st[i] = 0;
    forever begin
      @(negedge clk);
      cur = {gc.busy, gc.reject_invalid, gc.reject_full, gc.gate_down, gc.gate_is_up,
             gc.gate_up, gc.exit_signal, gc.entry_signal};
      if (mon_en) begin
        compared++;
        if (gc.gate_up && gc.gate_down) begin
          mism++;
          $display("FAIL motor_exclusive at cycle %0d: gate_up=1 gate_down=1, required not both", cyc);
        end
        compared++;
        if (gc.entry_signal && gc.exit_signal) begin
          mism++;
          $display("FAIL request_exclusive at cycle %0d: entry=1 exit=1, required not both", cyc);
        end
        for (int i = 0; i < 8; i++) begin
          if (cur[i] && !prv[i]) begin
            st[i] = cyc;
            if (i == K_EXIT) slot_seen = int'(gc.exit_slot);
          end else if (!cur[i] && prv[i]) begin
            check_pulse(i, st[i], cyc - st[i], slot_seen);
          end
        end
      end
      prv = cur;
    end
  end

  // One car on one lane from sensor rise to the moment both lane and controller are quiet.
  task automatic run_txn(input bit is_exit, input int slot, input int resp, input int k);
    int e, r, idle, drop, fin;
    e = cyc;
    if (is_exit) gc.exit_slot_sel = 2'(slot);
    set_raw(is_exit, 1'b1);
    r = e + DB + 1;
    plan(is_exit, slot, r, resp, k, idle);
    drop = (resp == RS_GRANT) ? r + 2 + MV + k : r + 2 + k;
    wait_to(drop);
    set_raw(is_exit, 1'b0);
    if (is_exit) gc.exit_slot_sel = 2'($urandom);
    fin = (idle > drop + DB + 1) ? idle : drop + DB + 1;
    wait_to(fin + 1 + int'($urandom_range(0, 4)));
  endtask

  // Entry and exit cars arrive together: exit is served, then the pending entry.
  task automatic run_simul(input int slot, input int resp1, input int k1, input int resp2, input int k2);
    int e, r1, r2, idle1, idle2, drop1, drop2, fin;
    e = cyc;
    gc.exit_slot_sel = 2'(slot);
    gc.car_at_exit = 1'b1;
    gc.car_at_entry = 1'b1;
    r1 = e + DB + 1;
    plan(1'b1, slot, r1, resp1, k1, idle1);
    drop1 = (resp1 == RS_GRANT) ? r1 + 2 + MV + k1 : r1 + 2 + k1;
    r2 = idle1 + 1;
    plan(1'b0, 0, r2, resp2, k2, idle2);
    drop2 = (resp2 == RS_GRANT) ? r2 + 2 + MV + k2 : r2 + 2 + k2;
    wait_to(drop1);
    gc.car_at_exit = 1'b0;
    wait_to(drop2);
    gc.car_at_entry = 1'b0;
    fin = (idle2 > drop2 + DB + 1) ? idle2 : drop2 + DB + 1;
    wait_to(fin + 2);
  endtask

  // An entry car appears and leaves while an exit is in PASS: it must never be requested.
  task automatic run_pend_drop(input int slot);
    int e, r1, idle1;
    e = cyc;
    gc.exit_slot_sel = 2'(slot);
    gc.car_at_exit = 1'b1;
    r1 = e + DB + 1;
    plan(1'b1, slot, r1, RS_GRANT, 20, idle1);
    wait_to(r1 + 3);
    gc.car_at_entry = 1'b1;
    wait_to(r1 + 11);
    gc.car_at_entry = 1'b0;
    wait_to(r1 + 2 + MV + 20);
    gc.car_at_exit = 1'b0;
    wait_to(idle1 + 3);
  endtask

  task automatic glitch(input bit is_exit, input int g);
    set_raw(is_exit, 1'b1);
    wait_to(cyc + g);
    set_raw(is_exit, 1'b0);
    wait_to(cyc + DB + 2);
  endtask

  initial begin
    int rr, resp, k;
    bit ex;
    logic [9:0] o;
    reset = 1'b0;
    gc.car_at_entry = 1'b0;
    gc.car_at_exit = 1'b0;
    gc.exit_slot_sel = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    o = outs_c();
    compared++;
    if (o !== 10'd0) begin
      mism++;
      $display("FAIL reset_state outputs got %b, required 0", o);
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    o = outs_c();
    compared++;
    if (o !== 10'd0) begin
      mism++;
      $display("FAIL post_reset_idle outputs got %b, required 0", o);
    end
    mon_en = 1'b1;

    // short raw pulses never produce a request
    glitch(1'b0, DB - 1);
    glitch(1'b1, DB - 1);
    gc.car_at_entry = 1'b1; wait_to(cyc + 3);
    gc.car_at_entry = 1'b0; wait_to(cyc + 1);
    gc.car_at_entry = 1'b1; wait_to(cyc + 3);
    gc.car_at_entry = 1'b0; wait_to(cyc + DB + 2);

    run_txn(1'b0, 0, RS_GRANT, 2);
    run_txn(1'b0, 0, RS_FULL, 9);
    run_txn(1'b1, 2, RS_GRANT, 3);
    run_txn(1'b1, 1, RS_DENY, 6);
    run_txn(1'b1, 3, RS_FULL, 1);
    run_txn(1'b0, 0, RS_DENY, 0);
    run_txn(1'b0, 0, RS_GRANT, 70);
    run_txn(1'b1, 0, RS_GRANT, 59);
    run_simul(2, RS_GRANT, 4, RS_GRANT, 1);
    run_simul(1, RS_DENY, 2, RS_FULL, 3);
    run_pend_drop(3);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) glitch(1'($urandom), int'($urandom_range(1, DB - 1)));
      rr = int'($urandom_range(0, 3));
      resp = (rr < 2) ? RS_GRANT : ((rr == 2) ? RS_FULL : RS_DENY);
      if (resp == RS_GRANT)
        k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 75)) : int'($urandom_range(0, 15));
      else
        k = int'($urandom_range(0, 10));
      if ($urandom_range(0, 7) == 0) begin
        run_simul(int'($urandom_range(0, 3)), (resp == RS_GRANT) ? RS_GRANT : RS_DENY,
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), int'($urandom_range(0, 10)));
      end else begin
        ex = 1'($urandom);
        run_txn(ex, int'($urandom_range(0, 3)), resp, k);
      end
    end

    wait_to(cyc + 10);
    compared++;
    if (exp_q.size() != 0) begin
      mism++;
      $display("FAIL scoreboard_drained got %0d pending pulses, required 0", exp_q.size());
    end

    // reset in the middle of raising the barrier
    mon_en = 1'b0;
    gc.car_at_entry = 1'b1;
    resp_q.push_back(RS_GRANT);
    wait_to(cyc + DB + 1 + 5);
    compared++;
    if (gc.gate_up !== 1'b1) begin
      mism++;
      $display("FAIL raise_before_reset gate_up got %b, required 1", gc.gate_up);
    end
    #3;
    reset = 1'b0;
    #1;
    o = outs_c();
    compared++;
    if (o !== 10'd0) begin
      mism++;
      $display("FAIL reset_mid_raise outputs got %b, required 0", o);
    end
    gc.car_at_entry = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
